// File: rtl/femto_pkg.sv
// femto_pkg: constants shared by the fetch-side blocks.
package femto_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int HW_W = 16;
    localparam logic [1:0] LEN32 = 2'b11;
endpackage

// File: rtl/instr_align_buffer.sv
// instr_align_buffer: halfword FIFO that reassembles 16/32-bit instructions from fetch words.
module instr_align_buffer
    import femto_pkg::*;
#(
    parameter int DEPTH_HW = 4,
    parameter logic [31:0] RESET_PC = femto_pkg::RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic [31:0]                 clr_pc,
    input  logic                        in_req,
    input  logic                        in_16bit,
    input  logic [31:0]                 in,
    output logic [$clog2(DEPTH_HW):0]   vacant_hw,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [31:0]                 out,
    output logic [31:0]                 out_pc,
    output logic                        out_c,
    output logic                        ovf_err
);
    localparam int AW = $clog2(DEPTH_HW);
    localparam logic [AW:0] DP = (AW+1)'(DEPTH_HW);
    typedef logic [HW_W-1:0] hw_t;

    // Pointer increment with wrap; DEPTH_HW need not be a power of two.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
        logic [AW:0] s;
        s = {1'b0, p} + {{(AW-1){1'b0}}, n};
        s = (s >= DP) ? s - DP : s;
        return s[AW-1:0];
    endfunction

    function automatic logic [AW:0] ext(input logic [1:0] n);
        return {{(AW-1){1'b0}}, n};
    endfunction

    hw_t           mem_q [DEPTH_HW];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d, vac;
    logic [31:0]   pc_q, pc_d;
    logic          skip_q, skip_d, ovf_q, ovf_d;
    hw_t           h0, h1, lo;
    logic          is32, pop, acc, drop;
    logic [1:0]    psh_n, pop_n;
    logic          unused_clr_pc0;

    assign unused_clr_pc0 = clr_pc[0];

    always_comb begin
        h0 = mem_q[rd_q];
        h1 = mem_q[ptr_add(rd_q, 2'd1)];
        is32 = h0[1:0] == LEN32;
        vac = DP - cnt_q;
        out_vld = (cnt_q != '0) && !(is32 && cnt_q == ext(2'd1));
        pop_n = is32 ? 2'd2 : 2'd1;
        pop = out_vld && out_rdy;
        // A pending skip turns the next 32-bit fetch into a single upper halfword.
        psh_n = (in_16bit || skip_q) ? 2'd1 : 2'd2;
        drop = in_req && (ext(psh_n) > vac);
        acc = in_req && !drop;
        lo = (skip_q && !in_16bit) ? in[31:16] : in[15:0];
        rd_d = clr ? '0 : pop ? ptr_add(rd_q, pop_n) : rd_q;
        wr_d = clr ? '0 : acc ? ptr_add(wr_q, psh_n) : wr_q;
        cnt_d = clr ? '0 : cnt_q + (acc ? ext(psh_n) : '0) - (pop ? ext(pop_n) : '0);
        pc_d = clr ? {clr_pc[31:1], 1'b0} : pop ? pc_q + (is32 ? 32'd4 : 32'd2) : pc_q;
        skip_d = clr ? clr_pc[1] : acc ? 1'b0 : skip_q;
        ovf_d = !clr && (ovf_q || drop);
    end

    assign vacant_hw = vac;
    assign out = is32 ? {h1, h0} : {16'h0, h0};
    assign out_c = !is32;
    assign out_pc = pc_q;
    assign ovf_err = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst && !clr && acc) begin
            mem_q[wr_q] <= lo;
            if (psh_n == 2'd2) mem_q[ptr_add(wr_q, 2'd1)] <= in[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            pc_q   <= RESET_PC;
            skip_q <= RESET_PC[1];
            ovf_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            skip_q <= skip_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule
